// File: rtl/if_id_buffer.sv
// IF/ID pipeline boundary: two-entry (main + skid) buffer with registered in_ready,
// branch flush and pre-split decode fields. Define IFID_PERF_CNT_EN for stall/flush counters.
module if_id_buffer #(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_instr,
    input  logic [DATA_W-1:0]  in_pc4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_instr,
    output logic [DATA_W-1:0]  out_pc4,
    output logic [FIELD_W-1:0] out_opcode,
    output logic [FIELD_W-1:0] out_rs,
    output logic [FIELD_W-1:0] out_rt,
    output logic [FIELD_W-1:0] out_rd
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    logic              mainValid;
    logic [DATA_W-1:0] mainInstr;
    logic [DATA_W-1:0] mainPc4;
    logic              skidValid;
    logic [DATA_W-1:0] skidInstr;
    logic [DATA_W-1:0] skidPc4;

    logic accept;
    logic drain;

    // in_ready comes straight from the skid flop, so it never depends on out_ready
    assign in_ready = ~skidValid;
    assign accept   = in_valid & in_ready;
    assign drain    = mainValid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mainValid <= 1'b0;
            mainInstr <= '0;
            mainPc4   <= '0;
            skidValid <= 1'b0;
            skidInstr <= '0;
            skidPc4   <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (drain && skidValid) begin
            mainInstr <= skidInstr;
            mainPc4   <= skidPc4;
            skidValid <= 1'b0;
        end else if (accept && (!mainValid || drain)) begin
            mainValid <= 1'b1;
            mainInstr <= in_instr;
            mainPc4   <= in_pc4;
        end else if (accept) begin
            skidValid <= 1'b1;
            skidInstr <= in_instr;
            skidPc4   <= in_pc4;
        end else if (drain) begin
            mainValid <= 1'b0;
        end
    end

    assign out_valid  = mainValid;
    assign out_instr  = mainInstr;
    assign out_pc4    = mainPc4;
    assign out_opcode = mainInstr[4*FIELD_W-1:3*FIELD_W];
    assign out_rs     = mainInstr[3*FIELD_W-1:2*FIELD_W];
    assign out_rt     = mainInstr[2*FIELD_W-1:FIELD_W];
    assign out_rd     = mainInstr[FIELD_W-1:0];

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;

    // Both counters saturate rather than wrap so long runs stay meaningful
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (in_valid && !in_ready && stallCnt != 16'hFFFF)
                stallCnt <= stallCnt + 16'd1;
            if (flush && (mainValid || skidValid) && flushCnt != 16'hFFFF)
                flushCnt <= flushCnt + 16'd1;
        end
    end

    assign stall_cnt = stallCnt;
    assign flush_cnt = flushCnt;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: stimulus queues words expected at decode,
// a negedge monitor pops and compares every consumed word.
module tb_if_id_buffer;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc4;
    } wordT;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc4;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rs;
    logic [3:0]  out_rt;
    logic [3:0]  out_rd;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    wordT expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    if_id_buffer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc4     (in_pc4),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc4    (out_pc4),
        .out_opcode (out_opcode),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of input; only words known to reach decode are queued
    task automatic applyStimulus(input logic valid, input logic [15:0] instr, input logic [15:0] pc4,
                                 input logic expectDelivered);
        wordT w;
        in_valid = valid;
        in_instr = instr;
        in_pc4   = pc4;
        if (expectDelivered) begin
            w.instr = instr;
            w.pc4   = pc4;
            expQ.push_back(w);
        end
        tick();
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWord: got %h, expected none", out_instr);
            end else begin
                wordT e;
                e = expQ.pop_front();
                pops++;
                checkOutput("outInstr", out_instr, e.instr);
                checkOutput("outPc4", out_pc4, e.pc4);
                checkOutput("outOpcode", {12'd0, out_opcode}, {12'd0, e.instr[15:12]});
                checkOutput("outRd", {12'd0, out_rd}, {12'd0, e.instr[3:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc4    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        checkOutput("resetOutValid", {15'd0, out_valid}, 16'd0);
        checkOutput("resetInReady", {15'd0, in_ready}, 16'd1);
        checkOutput("resetOutInstr", out_instr, 16'h0000);
        checkOutput("resetOutPc4", out_pc4, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Streaming at full rate, including drain+accept in the same edge
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h1234, 16'h0001, 1'b1);
        checkOutput("streamValid1", {15'd0, out_valid}, 16'd1);
        checkOutput("streamOpcode", {12'd0, out_opcode}, 16'd1);
        checkOutput("streamRs", {12'd0, out_rs}, 16'd2);
        checkOutput("streamRt", {12'd0, out_rt}, 16'd3);
        checkOutput("streamRd", {12'd0, out_rd}, 16'd4);
        applyStimulus(1'b1, 16'h5678, 16'h0002, 1'b1);
        checkOutput("streamNoBubble", out_instr, 16'h5678);
        checkOutput("streamReady", {15'd0, in_ready}, 16'd1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("streamEmpty", {15'd0, out_valid}, 16'd0);

        // Backpressure: A in main, B into skid, C refused until space frees
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'hA1A1, 16'h0010, 1'b1);
        checkOutput("bpReadyAfterA", {15'd0, in_ready}, 16'd1);
        applyStimulus(1'b1, 16'hB2B2, 16'h0011, 1'b1);
        checkOutput("bpReadyLow", {15'd0, in_ready}, 16'd0);
        checkOutput("bpHoldA", out_instr, 16'hA1A1);
        applyStimulus(1'b1, 16'hC3C3, 16'h0012, 1'b0);
        checkOutput("bpStillLow", {15'd0, in_ready}, 16'd0);
        checkOutput("bpStableA", out_instr, 16'hA1A1);
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'hC3C3, 16'h0012, 1'b0);
        checkOutput("bpReadyRise", {15'd0, in_ready}, 16'd1);
        checkOutput("bpMainB", out_instr, 16'hB2B2);
        applyStimulus(1'b1, 16'hC3C3, 16'h0012, 1'b1);
        checkOutput("bpMainC", out_instr, 16'hC3C3);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("bpDrained", {15'd0, out_valid}, 16'd0);

        // Flush with both entries full and a word offered
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'hD4D4, 16'h0020, 1'b0);
        applyStimulus(1'b1, 16'hE5E5, 16'h0021, 1'b0);
        flush = 1'b1;
        applyStimulus(1'b1, 16'hF6F6, 16'h0022, 1'b0);
        flush = 1'b0;
        checkOutput("flushFullValid", {15'd0, out_valid}, 16'd0);
        checkOutput("flushFullReady", {15'd0, in_ready}, 16'd1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("flushFullNoLeak", {15'd0, out_valid}, 16'd0);

        // Flush while in_ready is high: the offered word must still be dropped
        applyStimulus(1'b1, 16'h7777, 16'h0030, 1'b0);
        flush = 1'b1;
        applyStimulus(1'b1, 16'h8888, 16'h0031, 1'b0);
        flush = 1'b0;
        checkOutput("flushOpenValid", {15'd0, out_valid}, 16'd0);
        checkOutput("flushOpenReady", {15'd0, in_ready}, 16'd1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("flushOpenNoLeak", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h9ABC, 16'h0040, 1'b1);
        checkOutput("postFlushWord", out_instr, 16'h9ABC);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);

        // Asynchronous reset between edges while main holds a word
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'hCAFE, 16'h0050, 1'b0);
        in_valid = 1'b0;
        checkOutput("preResetValid", {15'd0, out_valid}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncRstValid", {15'd0, out_valid}, 16'd0);
        checkOutput("asyncRstInstr", out_instr, 16'h0000);
        checkOutput("asyncRstReady", {15'd0, in_ready}, 16'd1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

`ifdef IFID_PERF_CNT_EN
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 16'h1000 + 16'(i), 16'h0060, 1'b0);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("stallCnt", stall_cnt, 16'd8);
        checkOutput("flushCnt", flush_cnt, 16'd1);
        tick();
`endif

        tick();
        tick();
        checkOutput("queueEmpty", 16'(expQ.size()), 16'd0);
        checkOutput("wordsDelivered", 16'(pops), 16'd6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
